// File: rtl/regbank_pkg.sv
// Purpose: shared constants and types for the 8-entry write-side register bank.
//   NUM_REGS : number of registers in the bank
//   ADDR_W   : write address width
//   BYTE_W   : bits per byte lane
//   word_t / be_t : default-width (32-bit) word and byte-enable types
package regbank_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;

    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic [WORD_W-1:0]        word_t;
    typedef logic [WORD_W/BYTE_W-1:0] be_t;

endpackage

// File: rtl/regbank8_write_demux_be_reg.sv
// Purpose: WIDTH-bit byte-enabled register with a sticky valid flag.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   clr_i   : synchronous clear of data and valid (wins over load)
//   ld_i    : load strobe for the enabled lanes
//   be_i    : per-lane enables, bit i covers d_i[8i+7:8i]
//   d_i     : write data
//   q_o     : register contents, straight from flops
//   valid_o : set by the first load after reset/clear
module be_reg
    import regbank_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    ld_i,
    input  logic [WIDTH/8-1:0]      be_i,
    input  logic [WIDTH-1:0]        d_i,
    output logic [WIDTH-1:0]        q_o,
    output logic                    valid_o
);

    localparam int unsigned LANES = WIDTH / BYTE_W;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (ld_i) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    data_d[i*BYTE_W +: BYTE_W] = d_i[i*BYTE_W +: BYTE_W];
                end
            end
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/regbank8_write_demux.sv
// Purpose: write demux for eight WIDTH-bit registers; a 3-bit address steers one
//   byte-enabled write per cycle into r0..r7, all of which are output in parallel.
// Ports:
//   clk, reset         : clock and asynchronous active-high reset
//   wr_en, wr_addr     : write request and target register
//   wr_data, wr_be     : write data and byte-lane enables
//   clr                : synchronous clear of registers, valid flags and counter
//   r0..r7             : register contents
//   valid              : per-register "written since reset/clear" flags
//   wr_count           : saturating count of accepted writes
module regbank8_write_demux
    import regbank_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic                 clr,
    output logic [WIDTH-1:0]     r0,
    output logic [WIDTH-1:0]     r1,
    output logic [WIDTH-1:0]     r2,
    output logic [WIDTH-1:0]     r3,
    output logic [WIDTH-1:0]     r4,
    output logic [WIDTH-1:0]     r5,
    output logic [WIDTH-1:0]     r6,
    output logic [WIDTH-1:0]     r7,
    output logic [NUM_REGS-1:0]  valid,
    output logic [CNT_W-1:0]     wr_count
);

    logic                accept;
    logic [NUM_REGS-1:0] ld;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] valid_w;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // wr_addr/wr_data only matter once the write is accepted, so an idle bus
    // carrying X never reaches the registers.
    assign accept = wr_en && !clr && (|wr_be) &&
                    !((ZERO_R0 != 0) && (wr_addr == '0));

    always_comb begin
        ld = '0;
        if (accept) begin
            ld[wr_addr] = 1'b1;
        end
    end

    generate
        if (ZERO_R0 != 0) begin : g_r0_zero
            assign regs[0]    = '0;
            assign valid_w[0] = 1'b1;
        end else begin : g_r0_reg
            be_reg #(.WIDTH(WIDTH)) u_r0 (
                .clk_i   (clk),
                .rst_i   (reset),
                .clr_i   (clr),
                .ld_i    (ld[0]),
                .be_i    (wr_be),
                .d_i     (wr_data),
                .q_o     (regs[0]),
                .valid_o (valid_w[0])
            );
        end

        for (genvar n = 1; n < NUM_REGS; n++) begin : g_reg
            be_reg #(.WIDTH(WIDTH)) u_r (
                .clk_i   (clk),
                .rst_i   (reset),
                .clr_i   (clr),
                .ld_i    (ld[n]),
                .be_i    (wr_be),
                .d_i     (wr_data),
                .q_o     (regs[n]),
                .valid_o (valid_w[n])
            );
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign r0       = regs[0];
    assign r1       = regs[1];
    assign r2       = regs[2];
    assign r3       = regs[3];
    assign r4       = regs[4];
    assign r5       = regs[5];
    assign r6       = regs[6];
    assign r7       = regs[7];
    assign valid    = valid_w;
    assign wr_count = cnt_q;

endmodule
